// File: rtl/spi_eep_resp_pkg.sv
// spi_eep_pkg: shared types and sizes for the SPI calibration-EEPROM responder.
package spi_eep_pkg;
    localparam int FRAME_BITS = 16;
    localparam int ADDR_W = 6;
    localparam int CNT_W = 5;
    typedef enum logic [1:0] {OP_RD = 2'b00, OP_WR = 2'b01, OP_RSV = 2'b10} op_e;
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_EXEC} state_e;
    // Both 2'b10 and 2'b11 collapse to the reserved opcode.
    function automatic op_e decode_op(input logic [1:0] f);
        return f[1] ? OP_RSV : (f[0] ? OP_WR : OP_RD);
    endfunction
endpackage

// File: rtl/spi_eep_resp_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with rise/fall pulses on the synchronized level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] sh_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) sh_q <= {3{RST_VAL}};
        else     sh_q <= {sh_q[1:0], d_i};
    assign rise_o = sh_q[1] & ~sh_q[2];
    assign fall_o = ~sh_q[1] & sh_q[2];
endmodule

// File: rtl/spi_eep_resp.sv
// spi_eep_resp: SPI mode-0 responder modelling a 64x8 calibration EEPROM.
// Optional write-protect input enabled by defining SPI_EEP_WP_EN.
module spi_eep_resp
    import spi_eep_pkg::*;
#(
    parameter logic [7:0] INIT_VAL = 8'h00,
    parameter logic [7:0] ACK_VAL  = 8'hA5,
    parameter logic [7:0] ERR_VAL  = 8'hEE
) (
    input  logic clk,
    input  logic rst,
`ifdef SPI_EEP_WP_EN
    input  logic wp,
`endif
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic MISO,
    output logic frame_vld,
    output logic frame_err
);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    state_e state_q, state_d;
    logic ss_rise, ss_fall, sclk_rise, sclk_fall;
    logic [1:0] mosi_q;
    logic [FRAME_BITS-1:0] tx_q, tx_d, rx_q, rx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0] resp_q, resp_d;
    logic [7:0] mem_q [2**ADDR_W];
    logic wp_s, we;
    op_e op;
    logic [ADDR_W-1:0] addr;
    logic [7:0] data;

`ifdef SPI_EEP_WP_EN
    assign wp_s = wp;
`else
    assign wp_s = 1'b0;
`endif

    // SS_n idles high, so its synchronizer resets high to avoid a false fall.
    spi_sync_edge #(.RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst(rst), .d_i(SS_n), .rise_o(ss_rise), .fall_o(ss_fall)
    );
    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .d_i(SCLK), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) mosi_q <= '0;
        else     mosi_q <= {mosi_q[0], MOSI};

    always_ff @(posedge clk or posedge rst)
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;

    always_comb
        state_d = (state_q == ST_IDLE  && ss_fall) ? ST_SHIFT :
                  (state_q == ST_SHIFT && ss_rise) ? ST_EXEC  :
                  (state_q == ST_EXEC)             ? ST_IDLE  : state_q;

    always_comb begin
        MISO      = (state_q == ST_SHIFT) && tx_q[FRAME_BITS-1];
        frame_vld = (state_q == ST_EXEC) && cnt_q == CNT_FULL;
        frame_err = (state_q == ST_EXEC) && cnt_q != CNT_FULL;
    end

    assign op   = decode_op(rx_q[15:14]);
    assign addr = rx_q[13:8];
    assign data = rx_q[7:0];
    assign we   = frame_vld && op == OP_WR && !wp_s;

    always_comb begin
        tx_d   = (state_q == ST_IDLE && ss_fall)    ? {8'h00, resp_q} :
                 (state_q == ST_SHIFT && sclk_fall) ? {tx_q[FRAME_BITS-2:0], 1'b0} : tx_q;
        rx_d   = (state_q == ST_SHIFT && sclk_rise) ? {rx_q[FRAME_BITS-2:0], mosi_q[1]} : rx_q;
        cnt_d  = (state_q == ST_IDLE) ? '0 :
                 (state_q == ST_SHIFT && sclk_rise && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        resp_d = frame_err    ? ERR_VAL :
                 !frame_vld   ? resp_q :
                 op == OP_RD  ? mem_q[addr] :
                 op == OP_WR  ? (wp_s ? ERR_VAL : ACK_VAL) : 8'h00;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            tx_q   <= '0;
            rx_q   <= '0;
            cnt_q  <= '0;
            resp_q <= 8'h00;
        end else begin
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            cnt_q  <= cnt_d;
            resp_q <= resp_d;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i < 2**ADDR_W; i++) mem_q[i] <= INIT_VAL;
        else if (we) mem_q[addr] <= data;
endmodule

// File: tb/tb_spi_eep_resp.sv
// tb_spi_eep_resp: bit-banged SPI frames checked against a behavioural EEPROM model.
module tb_spi_eep_resp;
    localparam logic [7:0] INIT_VAL = 8'h00;
    localparam logic [7:0] ACK_VAL  = 8'hA5;
    localparam logic [7:0] ERR_VAL  = 8'hEE;

    logic clk = 1'b0;
    logic rst, SS_n, SCLK, MOSI, MISO, frame_vld, frame_err;
    logic wp = 1'b0;
    int checks = 0, errors = 0;
    logic [7:0] mem_m [64];
    logic [7:0] resp_m;
    logic [15:0] miso_w;

    always #5 clk = ~clk;

    spi_eep_resp dut (
        .clk(clk),
        .rst(rst),
`ifdef SPI_EEP_WP_EN
        .wp(wp),
`endif
        .SS_n(SS_n),
        .SCLK(SCLK),
        .MOSI(MOSI),
        .MISO(MISO),
        .frame_vld(frame_vld),
        .frame_err(frame_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_model();
        foreach (mem_m[i]) mem_m[i] = INIT_VAL;
        resp_m = 8'h00;
    endtask

    // EEPROM behaviour: what a completed frame does to the array and the next response.
    task automatic model(input int n, input logic [31:0] w);
        if (n != 16) resp_m = ERR_VAL;
        else if (w[15]) resp_m = 8'h00;
        else if (!w[14]) resp_m = mem_m[w[13:8]];
        else if (wp) resp_m = ERR_VAL;
        else begin
            mem_m[w[13:8]] = w[7:0];
            resp_m = ACK_VAL;
        end
    endtask

    task automatic shift_bits(input int n, input logic [31:0] w);
        for (int i = 0; i < n; i++) begin
            MOSI = w[n-1-i];
            clk_n(5);
            if (i < 16) miso_w[15-i] = MISO;
            SCLK = 1'b1;
            clk_n(5);
            SCLK = 1'b0;
        end
    endtask

    task automatic frame(input int n, input logic [31:0] w);
        int nv, ne, k;
        logic [15:0] mask, exp;
        nv = 0;
        ne = 0;
        exp = {8'h00, resp_m};
        k = n < 16 ? n : 16;
        mask = 16'hFFFF << (16 - k);
        miso_w = '0;
        SS_n = 1'b0;
        clk_n(5);
        shift_bits(n, w);
        clk_n(5);
        SS_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            nv += int'(frame_vld);
            ne += int'(frame_err);
        end
        if (n > 0) check("miso", 32'(miso_w & mask), 32'(exp & mask));
        check("frame_vld", nv, n == 16 ? 1 : 0);
        check("frame_err", ne, n == 16 ? 0 : 1);
        model(n, w);
    endtask

    initial begin
        int nv, ne, r, n;
        logic [31:0] w;
        rst = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        reset_model();
        clk_n(3);
        rst = 1'b0;
        clk_n(2);
        check("rst_miso", MISO, 0);
        check("rst_vld", frame_vld, 0);
        check("rst_err", frame_err, 0);

        frame(16, 32'h0000);
        frame(16, 32'h0000);
        frame(16, 32'h4A3C);
        frame(16, 32'h0A00);
        frame(16, 32'h0000);
        frame(16, 32'h7F81);
        frame(16, 32'h3F00);
        frame(16, 32'h0000);
        frame(16, 32'h0000);

        frame(15, 32'h4011);
        frame(17, 32'h08022);
        frame(16, 32'h0000);
        frame(0, 32'h0);
        frame(16, 32'h0100);
        frame(16, 32'hC000);
        frame(16, 32'h0000);

        frame(16, 32'h45AB);
        SS_n = 1'b0;
        clk_n(5);
        shift_bits(8, 32'h45);
        rst = 1'b1;
        clk_n(2);
        check("midrst_miso", MISO, 0);
        SS_n = 1'b1;
        clk_n(2);
        rst = 1'b0;
        nv = 0;
        ne = 0;
        repeat (12) begin
            @(negedge clk);
            nv += int'(frame_vld);
            ne += int'(frame_err);
        end
        check("midrst_pulses", nv + ne, 0);
        reset_model();
        frame(16, 32'h0500);
        frame(16, 32'h0000);

`ifdef SPI_EEP_WP_EN
        wp = 1'b1;
        frame(16, 32'h5055);
        frame(16, 32'h1000);
        frame(16, 32'h0000);
        wp = 1'b0;
`endif

        for (int t = 0; t < 24; t++) begin
            r = int'($urandom_range(0, 9));
            n = r == 0 ? 0 : r == 1 ? 15 : r == 2 ? 17 : 16;
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[13:8] = 6'($urandom_range(0, 3));
            if (r == 3) w[13:8] = 6'h3F;
            frame(n, w);
        end
        frame(16, 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
